serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 52 +++++
 rtl/serial_addsub.sv | 173 +++++++++++++++++
 tb/tb_serial_addsub.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// ============================================================================
// Module      : serial_addsub_if
// Description : Operation request / result bundle for the bit-serial
//               adder/subtractor. The ovf signal exists only when
//               SERIAL_ADDSUB_OVF_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;

    // Requester side: issues operations, observes results
    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    // Arithmetic unit side
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
`else
    // Requester side: issues operations, observes results
    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout
    );

    // Arithmetic unit side
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout
    );
`endif

endinterface

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial two's-complement adder/subtractor. A single
//               1-bit full-adder cell and a carry flip-flop process one bit
//               per clock, LSB first. Subtraction is a + ~b + 1, done by
//               loading B inverted and presetting the carry to 1.
//               Optional macro SERIAL_ADDSUB_OVF_EN adds the signed
//               overflow flag (ovf) to the result.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_addsub_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter only needs to reach WIDTH-1 (index of the MSB stage).
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;

    // Operand shift registers; B already holds ~B for a subtract.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;

    // Partial result; one bit narrower than the result because the MSB is
    // produced combinationally on the final shift edge.
    logic [WIDTH-2:0] res_sr;

    logic             carry;

    // Architecturally visible result registers.
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] res_next;

    // One full-adder cell on the current LSBs plus the carry flip-flop
    always_comb begin
        fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
        fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // Handshake qualifiers and the next result image after this shift
    always_comb begin
        last_bit = (bit_cnt == LAST_BIT);
        accept   = (state == ST_IDLE) && bus.start;
        finish   = (state == ST_SHIFT) && last_bit;
        res_next = {fa_sum, res_sr};
    end

    // ------------------------------------------------------------------------
    // Control FSM and bit counter
    // ------------------------------------------------------------------------
    // Sequences IDLE -> SHIFT (WIDTH edges) -> DONE (one cycle) -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here: no queuing.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------------
    // Captures operands on acceptance, then shifts one bit per SHIFT edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
        end else if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.sub ? ~bus.b : bus.b;
            res_sr <= '0;
            // Carry preset to 1 supplies the "+1" of a + ~b + 1.
            carry  <= bus.sub;
        end else if (state == ST_SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next[WIDTH-1:1];
            carry  <= fa_carry;
        end
    end

    // ------------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------------
    // Latched only on the final shift edge so partial sums never appear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (finish) begin
            sum_q  <= res_next;
            cout_q <= fa_carry;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB stage differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (finish) begin
            ovf_q <= carry ^ fa_carry;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy = (state == ST_SHIFT) || (state == ST_DONE);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub. Directed corner
//               operations, reset abort, back-to-back spacing and random
//               operations, all checked against an arithmetic model.
//               Honours SERIAL_ADDSUB_OVF_EN for the ovf checks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

    localparam int W = 8;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    // Last result the model says the DUT is holding on sum.
    logic [W-1:0] model_sum = '0;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] sm, output logic c, output logic v);
        longint ua, ub, sa, sb, r;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (longint'(1) <<< W) : ua;
        sb = b[W-1] ? ub - (longint'(1) <<< W) : ub;
        r  = s ? sa - sb : sa + sb;
        v  = (r > (longint'(1) <<< (W-1)) - 1) || (r < -(longint'(1) <<< (W-1)));
        sm = s ? W'(ua - ub) : W'(ua + ub);
        c  = s ? (ua >= ub) : ((ua + ub) >= (longint'(1) <<< W));
    endfunction

    // Issue one operation from a negedge and check the result.
    // scramble: change a/b/sub while shifting; poke: pulse start while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit scramble, input bit poke, input string tag);
        logic [W-1:0] e_sum;
        logic         e_c;
        logic         e_v;
        int           k;
        int           extra;
        model(a, b, s, e_sum, e_c, e_v);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (bus.done !== 1'b1 && k <= 3 * W) begin
            if (k == W) check({tag, "_hold"}, 32'(bus.sum), 32'(model_sum));
            if (scramble) begin
                bus.a   = W'($urandom);
                bus.b   = W'($urandom);
                bus.sub = 1'($urandom);
            end
            if (poke) bus.start = (k == 3);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_lat"}, 32'(k), 32'(W + 1));
            check({tag, "_sum"}, 32'(bus.sum), 32'(e_sum));
            check({tag, "_cout"}, 32'(bus.cout), 32'(e_c));
`ifdef SERIAL_ADDSUB_OVF_EN
            check({tag, "_ovf"}, 32'(bus.ovf), 32'(e_v));
`endif
            model_sum = e_sum;
            if (poke) bus.start = 1'b1;   // start in the DONE cycle
            @(negedge clk);
            bus.start = 1'b0;
            check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            if (poke) begin
                extra = 0;
                repeat (W + 3) begin
                    @(negedge clk);
                    if (bus.done === 1'b1) extra++;
                end
                check({tag, "_no_queue"}, 32'(extra), 32'd0);
            end
        end
    endtask

    initial begin
        logic [W-1:0] e_sum;
        logic         e_c;
        logic         e_v;
        int           dones;
        int           last_cyc;
        int           cnt;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);

        // start in the very first edge after reset release
        rst = 1'b0;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, "add5a3c");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, "addff01");
        run_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, "sub1020");
        run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, "sub8001");
        run_op(8'h37, 8'h37, 1'b1, 1'b1, 1'b0, "subeq");
        run_op(8'h7F, 8'h7F, 1'b0, 1'b1, 1'b0, "add7f7f");

        // Reset on the 4th SHIFT cycle aborts with no done
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        bus.b     = 8'h3C;
        bus.sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
        model_sum = '0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, "add0102");

        // Back-to-back with start held high
        model(8'hC3, 8'h4E, 1'b1, e_sum, e_c, e_v);
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'h4E;
        bus.sub   = 1'b1;
        dones     = 0;
        last_cyc  = 0;
        for (int cyc = 0; cyc < 4 * (W + 2) + 4 && dones < 3; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                check("b2b_sum", 32'(bus.sum), 32'(e_sum));
                check("b2b_cout", 32'(bus.cout), 32'(e_c));
                if (dones > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'(W + 2));
                last_cyc = cyc;
                dones++;
            end
        end
        bus.start = 1'b0;
        check("b2b_count", 32'(dones), 32'd3);
        model_sum = e_sum;
        repeat (W + 3) @(negedge clk);

        // Random operations
        for (int i = 0; i < 16; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, (i % 4) == 0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop so the run can never hang
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
